btn_toggle_conditioner: RTL and testbench
=========================================

// Module: btn_toggle_conditioner
// PURPOSE
//   Converts a raw, asynchronous, bouncing push-button into a clean single-cycle
//   toggle-enable pulse (t_pulse) that drives the T input of the toggle flip-flop
//   stage directly downstream.
//   - Synchronises the button input and debounces it with a 4-state FSM.
//   - Exports the debounced level, press/release pulses and a bounce counter for lab debug.
// PARAMETERS
//   SYNC_STAGES      2      synchroniser flops on btn_raw (legal: >=2)
//   DEBOUNCE_CYCLES  500000 consecutive stable synced samples to accept a change (legal: >=2)
//   BTN_ACTIVE_LOW   0      1: pressed = btn_raw low; inverted before the synchroniser
//   BOUNCE_W         8      width of the saturating bounce counter
// PORTS
//   clk          in   1         system clock
//   rstn         in   1         asynchronous active-low reset
//   btn_raw      in   1         raw button pin, asynchronous to clk
//   t_pulse      out  1         1-cycle pulse on each accepted press (feeds T)
//   rel_pulse    out  1         1-cycle pulse on each accepted release
//   btn_level    out  1         debounced pressed level
//   busy         out  1         high while in PRESS_WAIT or REL_WAIT
//   bounce_cnt   out  BOUNCE_W  number of aborted transitions, saturating
// BEHAVIOUR
//   Reset: rstn is asynchronous, active-low; clock is clk. While rstn=0:
//   - all outputs = 0; synchroniser flops = not-pressed; FSM = IDLE; counter = 0.
//   - Reset asserted mid-count abandons the count; no pulse is generated.
//   Input path: p = btn_raw ^ BTN_ACTIVE_LOW -> SYNC_STAGES flops -> s. Only s is used downstream.
//   Counter cnt: width $clog2(DEBOUNCE_CYCLES+1), local.
//   FSM, evaluated on each rising edge of clk:
//   - IDLE:     s=1 -> PRESS_WAIT, cnt=1; otherwise stay.
//   - PRESS_WAIT:
//       s=0 -> IDLE, bounce_cnt++.
//       s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, t_pulse=1 for 1 cycle.
//       s=1 otherwise -> cnt++.
//   - PRESSED:  s=0 -> REL_WAIT, cnt=1; otherwise stay.
//   - REL_WAIT: mirror of PRESS_WAIT with s inverted.
//       s=1 -> PRESSED, bounce_cnt++, no pulse.
//       completion -> IDLE, rel_pulse=1 for 1 cycle.
//   Output timing:
//   - t_pulse and rel_pulse are registered, high exactly one cycle, never high together.
//   - Never two t_pulses without an intervening rel_pulse.
//   - btn_level = 1 in PRESSED and REL_WAIT; it rises in the same cycle as t_pulse.
//   Latency: first edge sampling p=1 is edge 1; t_pulse rises at edge SYNC_STAGES+DEBOUNCE_CYCLES.
//     Release latency is symmetric.
//   bounce_cnt saturates at all-ones with no wrap; it is cleared only by reset.
//   A pulse shorter than DEBOUNCE_CYCLES synced samples never produces t_pulse.
//   Held button: exactly one t_pulse, no auto-repeat.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=0)
//   1. Clean press (btn_raw 0->1, held 20 cycles)
//      -> t_pulse high 1 cycle at edge 6; btn_level=1 from edge 6; bounce_cnt=0.
//   2. Bounce: 1,0,1,1,0 pattern of single cycles, then held high
//      -> bounce_cnt=2; exactly one t_pulse, 4 stable samples after the last bounce.
//   3. Glitch: btn_raw high for 3 cycles, then low
//      -> no t_pulse; btn_level stays 0; bounce_cnt=1.
//   4. Release after test 1 (btn_raw 1->0, held)
//      -> rel_pulse 1 cycle at edge 6 after the falling sample; btn_level=0 with it.
//   5. rstn pulsed low during PRESS_WAIT (cnt=2)
//      -> outputs 0 immediately; no pulse after release of reset;
//         a held button then needs the full 6 edges.
//   6. BTN_ACTIVE_LOW=1, BOUNCE_W=2, 5 aborted presses
//      -> pressed when btn_raw=0; bounce_cnt saturates at 3.

Source files
------------

// File: rtl/btn_toggle_conditioner_if.sv
// Button-conditioner port bundle: the raw pin in, the clean pulses and debug status out.
// The conditioner takes the slave view and the pin driver takes the master view.
interface btn_toggle_conditioner_if #(
    parameter int BOUNCE_W = 8
);
    logic                btn_raw;
    logic                t_pulse;
    logic                rel_pulse;
    logic                btn_level;
    logic                busy;
    logic [BOUNCE_W-1:0] bounce_cnt;

    modport master (
        output btn_raw,
        input  t_pulse,
        input  rel_pulse,
        input  btn_level,
        input  busy,
        input  bounce_cnt
    );

    modport slave (
        input  btn_raw,
        output t_pulse,
        output rel_pulse,
        output btn_level,
        output busy,
        output bounce_cnt
    );
endinterface

// File: rtl/btn_toggle_conditioner.sv
// Synchronises and debounces a raw push-button. It produces a one-cycle toggle-enable
// pulse on each accepted press, plus release, level, busy and bounce-count outputs for debug.
module btn_toggle_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 0,
    parameter int BOUNCE_W        = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    btn_toggle_conditioner_if.slave bus
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             ACT_LOW  = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_REL_WAIT   = 2'd3
    } state_t;

    logic                   p_s;
    logic                   s_s;
    logic [SYNC_STAGES-1:0] sync_r;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   bounce_inc_s;
    logic                   t_nxt_s;
    logic                   rel_nxt_s;
    logic                   level_nxt_s;
    logic                   busy_nxt_s;
    logic                   t_pulse_r;
    logic                   rel_pulse_r;
    logic                   btn_level_r;
    logic                   busy_r;
    logic [BOUNCE_W-1:0]    bounce_r;

    // Normalise polarity before the synchroniser so that 0 always means not-pressed.
    assign p_s = bus.btn_raw ^ ACT_LOW;
    assign s_s = sync_r[SYNC_STAGES-1];

    // Metastability synchroniser shift chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], p_s};
        end
    end

    // FSM state, stability counter and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            t_pulse_r   <= 1'b0;
            rel_pulse_r <= 1'b0;
            btn_level_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            t_pulse_r   <= t_nxt_s;
            rel_pulse_r <= rel_nxt_s;
            btn_level_r <= level_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Next-state logic. Each WAIT state counts consecutive agreeing samples and aborts on any disagreement.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        bounce_inc_s = 1'b0;
        t_nxt_s      = 1'b0;
        rel_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s_s) begin
                    state_nxt_s = ST_PRESS_WAIT;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s_s) begin
                    state_nxt_s  = ST_IDLE;
                    bounce_inc_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_PRESSED;
                    t_nxt_s     = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s_s) begin
                    state_nxt_s = ST_REL_WAIT;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_REL_WAIT: begin
                if (s_s) begin
                    state_nxt_s  = ST_PRESSED;
                    bounce_inc_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    rel_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Level and busy are decoded from the next state, so they are registered in step with the pulses.
    assign level_nxt_s = (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_REL_WAIT);
    assign busy_nxt_s  = (state_nxt_s == ST_PRESS_WAIT) || (state_nxt_s == ST_REL_WAIT);

    // Saturating count of aborted transitions
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bounce_r <= '0;
        end else if (bounce_inc_s && !(&bounce_r)) begin
            bounce_r <= bounce_r + BOUNCE_W'(1);
        end else begin
            bounce_r <= bounce_r;
        end
    end

    assign bus.t_pulse    = t_pulse_r;
    assign bus.rel_pulse  = rel_pulse_r;
    assign bus.btn_level  = btn_level_r;
    assign bus.busy       = busy_r;
    assign bus.bounce_cnt = bounce_r;
endmodule

// File: tb/tb_btn_toggle_conditioner.sv
// Drives an active-high and an active-low conditioner with the same logical press pattern.
// Outputs are compared every cycle against a run-length debounce model, plus directed checks.
module tb_btn_toggle_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk;
    logic rstn;

    btn_toggle_conditioner_if #(.BOUNCE_W(8)) ifa ();
    btn_toggle_conditioner_if #(.BOUNCE_W(2)) ifb ();

    btn_toggle_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(0), .BOUNCE_W(8)
    ) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));

    btn_toggle_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1), .BOUNCE_W(2)
    ) dut_b (.clk(clk), .rstn(rstn), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the pressed level is accepted after DEB consecutive disagreeing samples.
    bit hist_q[$];
    int run_len;
    bit level;
    int bounces;
    bit exp_t;
    bit exp_r;

    // Directed bookkeeping for dut_a
    int edge_no;
    int t_seen;
    int t_edge;
    int r_seen;
    int r_edge;

    task automatic model_reset();
        hist_q = {};
        for (int i = 0; i < SYNC; i++) hist_q.push_back(1'b0);
        run_len = 0;
        level   = 1'b0;
        bounces = 0;
        exp_t   = 1'b0;
        exp_r   = 1'b0;
    endtask

    task automatic model_edge(input bit p);
        bit s;
        hist_q.push_back(p);
        s = hist_q.pop_front();
        exp_t = 1'b0;
        exp_r = 1'b0;
        if (s != level) begin
            run_len++;
            if (run_len == DEB) begin
                level   = s;
                exp_t   = s;
                exp_r   = !s;
                run_len = 0;
            end
        end else begin
            if (run_len > 0) bounces++;
            run_len = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("a_t_pulse",   32'(ifa.t_pulse),    32'(exp_t));
        chk("a_rel_pulse", 32'(ifa.rel_pulse),  32'(exp_r));
        chk("a_level",     32'(ifa.btn_level),  32'(level));
        chk("a_busy",      32'(ifa.busy),       32'(run_len > 0));
        chk("a_bounce",    32'(ifa.bounce_cnt), 32'((bounces > 255) ? 255 : bounces));
        chk("b_t_pulse",   32'(ifb.t_pulse),    32'(exp_t));
        chk("b_rel_pulse", 32'(ifb.rel_pulse),  32'(exp_r));
        chk("b_level",     32'(ifb.btn_level),  32'(level));
        chk("b_busy",      32'(ifb.busy),       32'(run_len > 0));
        chk("b_bounce",    32'(ifb.bounce_cnt), 32'((bounces > 3) ? 3 : bounces));
    endtask

    task automatic mark();
        edge_no = 1;
        t_seen  = 0;
        t_edge  = 0;
        r_seen  = 0;
        r_edge  = 0;
    endtask

    // One clock with logical press value p: dut_b sees the inverted pin.
    task automatic cyc(input bit p);
        ifa.btn_raw = p;
        ifb.btn_raw = ~p;
        @(posedge clk);
        model_edge(p);
        #1;
        check_all();
        if (ifa.t_pulse === 1'b1) begin
            t_seen++;
            t_edge = edge_no;
        end
        if (ifa.rel_pulse === 1'b1) begin
            r_seen++;
            r_edge = edge_no;
        end
        edge_no++;
    endtask

    task automatic do_reset();
        ifa.btn_raw = 1'b0;
        ifb.btn_raw = 1'b1;
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        #4;
        mark();
    endtask

    initial begin
        bit p;
        int hold;
        rstn = 1'b0;
        ifa.btn_raw = 1'b0;
        ifb.btn_raw = 1'b1;
        model_reset();
        mark();

        // Reset state
        do_reset();
        chk("reset_level", 32'(ifa.btn_level), 32'd0);
        chk("reset_bounce", 32'(ifa.bounce_cnt), 32'd0);

        // 1: clean press held 20 cycles
        for (int i = 0; i < 20; i++) cyc(1'b1);
        chk("t1_t_edge", 32'(t_edge), 32'd6);
        chk("t1_t_count", 32'(t_seen), 32'd1);
        chk("t1_level", 32'(ifa.btn_level), 32'd1);
        chk("t1_bounce", 32'(ifa.bounce_cnt), 32'd0);

        // 4: release after the clean press
        mark();
        for (int i = 0; i < 10; i++) cyc(1'b0);
        chk("t4_rel_edge", 32'(r_edge), 32'd6);
        chk("t4_rel_count", 32'(r_seen), 32'd1);
        chk("t4_level", 32'(ifa.btn_level), 32'd0);

        // 2: bounce pattern then held high
        do_reset();
        cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1);
        chk("t2_bounce", 32'(ifa.bounce_cnt), 32'd2);
        chk("t2_t_count", 32'(t_seen), 32'd1);
        chk("t2_t_edge", 32'(t_edge), 32'd11);

        // 3: glitch shorter than the debounce window
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0);
        chk("t3_t_count", 32'(t_seen), 32'd0);
        chk("t3_level", 32'(ifa.btn_level), 32'd0);
        chk("t3_bounce", 32'(ifa.bounce_cnt), 32'd1);

        // 5: reset asserted mid-count with the button held
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1);
        chk("t5_busy_before", 32'(ifa.busy), 32'd1);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t5_busy_async", 32'(ifa.busy), 32'd0);
        chk("t5_t_async", 32'(ifa.t_pulse), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #4;
        mark();
        for (int i = 0; i < 10; i++) cyc(1'b1);
        chk("t5_t_edge", 32'(t_edge), 32'd6);
        chk("t5_t_count", 32'(t_seen), 32'd1);

        // 6: five aborted presses; the 2-bit counter on dut_b saturates
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
        end
        chk("t6_a_bounce", 32'(ifa.bounce_cnt), 32'd5);
        chk("t6_b_bounce", 32'(ifb.bounce_cnt), 32'd3);
        chk("t6_b_level", 32'(ifb.btn_level), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1);
        chk("t6_b_pressed_low", 32'(ifb.btn_level), 32'd1);

        // Randomised run lengths straddling the debounce window
        do_reset();
        p = 1'b0;
        for (int k = 0; k < 600; k++) begin
            p = ~p;
            hold = $urandom_range(1, 9);
            for (int i = 0; i < hold; i++) cyc(p);
        end
        for (int i = 0; i < 12; i++) cyc(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
